// File: rtl/iram_access_ctrl.sv
// iram_access_ctrl
// Sequences 8051 execute-stage accesses to the internal RAM/SFR array.
// Byte and bit requests arrive over a req/done handshake. Bit addresses are
// translated to a byte address and a bit index. A bit write is done as a
// read-modify-write, so the RAM only ever sees plain byte read/write strobes.
module iram_access_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int RD_LATENCY    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req,
  input  logic [1:0]               op,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [7:0]               wdata,
  input  logic                     wbit,
  output logic                     busy,
  output logic                     done,
  output logic [7:0]               rdata,
  output logic                     rbit,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic                     ram_rd,
  output logic                     ram_wr,
  output logic [7:0]               ram_wdata,
  input  logic [7:0]               ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_BYTE_RD = 2'b00;
  localparam logic [1:0] OP_BYTE_WR = 2'b01;
  localparam logic [1:0] OP_BIT_RD  = 2'b10;
  localparam logic [1:0] OP_BIT_WR  = 2'b11;

  // The read wait count runs 0..RD_LATENCY-1; the last value is the capture cycle.
  localparam logic [1:0] LAST_WAIT = 2'(RD_LATENCY - 1);

  // Bit addresses below 0x80 live in bytes 0x20..0x2F; the rest are SFR bytes
  // whose address is the bit address with the low three bits cleared.
  localparam logic [ADDRESS_WIDTH-1:0] BIT_AREA_BASE = ADDRESS_WIDTH'(8'h20);

  state_t     state;
  logic [1:0] op_q;
  logic [2:0] bit_idx;
  logic       wbit_q;
  logic [1:0] wait_cnt;
  logic [7:0] merged_byte;

  function automatic logic [ADDRESS_WIDTH-1:0] map_bit_addr(
    input logic [ADDRESS_WIDTH-1:0] a
  );
    if (a[ADDRESS_WIDTH-1]) begin
      return {a[ADDRESS_WIDTH-1:3], 3'b000};
    end
    return BIT_AREA_BASE + ADDRESS_WIDTH'(a[6:3]);
  endfunction

  // Read data with only the addressed bit replaced, for the write-back half of a bit write.
  always_comb begin
    merged_byte          = ram_rdata;
    merged_byte[bit_idx] = wbit_q;
  end

  // Access sequencer: all outputs are registered and set on the edge entering the state that owns them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      op_q      <= OP_BYTE_RD;
      bit_idx   <= 3'd0;
      wbit_q    <= 1'b0;
      wait_cnt  <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= 8'h00;
      rbit      <= 1'b0;
      ram_addr  <= '0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
      ram_wdata <= 8'h00;
    end else begin
      done   <= 1'b0;
      ram_rd <= 1'b0;
      ram_wr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            op_q     <= op;
            bit_idx  <= addr[2:0];
            wbit_q   <= wbit;
            wait_cnt <= 2'd0;
            busy     <= 1'b1;
            ram_addr <= op[1] ? map_bit_addr(addr) : addr;
            if (op == OP_BYTE_WR) begin
              ram_wr    <= 1'b1;
              ram_wdata <= wdata;
            end else begin
              ram_rd <= 1'b1;
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_q == OP_BYTE_WR) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            case (op_q)
              OP_BYTE_RD: begin
                rdata <= ram_rdata;
                done  <= 1'b1;
                state <= S_DONE;
              end
              OP_BIT_RD: begin
                rbit  <= ram_rdata[bit_idx];
                done  <= 1'b1;
                state <= S_DONE;
              end
              OP_BIT_WR: begin
                ram_wr    <= 1'b1;
                ram_wdata <= merged_byte;
                state     <= S_WRITE;
              end
              default: begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            endcase
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: begin
          busy      <= 1'b0;
          ram_addr  <= '0;
          ram_wdata <= 8'h00;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iram_access_ctrl.sv
// tb_iram_access_ctrl
// Directed bench for iram_access_ctrl. Two instances run side by side: one with
// a single-cycle RAM read latency and one with a three-cycle latency, each
// backed by its own small RAM model.
module tb_iram_access_ctrl;

  logic clock = 1'b0;
  logic reset;

  logic       req1, wbit1, busy1, done1, rbit1, ram_rd1, ram_wr1;
  logic [1:0] op1;
  logic [7:0] addr1, wdata1, rdata1, ram_addr1, ram_wdata1, ram_rdata1;

  logic       req3, wbit3, busy3, done3, rbit3, ram_rd3, ram_wr3;
  logic [1:0] op3;
  logic [7:0] addr3, wdata3, rdata3, ram_addr3, ram_wdata3, ram_rdata3;

  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];

  int checks = 0;
  int failures = 0;
  int rd_cnt1 = 0, wr_cnt1 = 0, both1 = 0;
  int rd_cnt3 = 0, wr_cnt3 = 0, both3 = 0;

  iram_access_ctrl #(.ADDRESS_WIDTH(8), .RD_LATENCY(1)) u_dut1 (
    .clock(clock), .reset(reset), .req(req1), .op(op1), .addr(addr1),
    .wdata(wdata1), .wbit(wbit1), .busy(busy1), .done(done1), .rdata(rdata1),
    .rbit(rbit1), .ram_addr(ram_addr1), .ram_rd(ram_rd1), .ram_wr(ram_wr1),
    .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
  );

  iram_access_ctrl #(.ADDRESS_WIDTH(8), .RD_LATENCY(3)) u_dut3 (
    .clock(clock), .reset(reset), .req(req3), .op(op3), .addr(addr3),
    .wdata(wdata3), .wbit(wbit3), .busy(busy3), .done(done3), .rdata(rdata3),
    .rbit(rbit3), .ram_addr(ram_addr3), .ram_rd(ram_rd3), .ram_wr(ram_wr3),
    .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3)
  );

  always #5 clock = ~clock;

  assign ram_rdata1 = pipe1;
  assign ram_rdata3 = pipe3[2];

  // RAM model, latency 1: read data is valid only in the single cycle after the strobe.
  always @(posedge clock) begin
    pipe1 <= ram_rd1 ? mem1[ram_addr1] : 8'h5A;
    if (ram_wr1) mem1[ram_addr1] <= ram_wdata1;
  end

  // RAM model, latency 3: read data walks through three stages.
  always @(posedge clock) begin
    pipe3[0] <= ram_rd3 ? mem3[ram_addr3] : 8'h5A;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
    if (ram_wr3) mem3[ram_addr3] <= ram_wdata3;
  end

  // Strobe monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (ram_rd1 === 1'b1) rd_cnt1++;
    if (ram_wr1 === 1'b1) wr_cnt1++;
    if (ram_rd1 === 1'b1 && ram_wr1 === 1'b1) both1++;
    if (ram_rd3 === 1'b1) rd_cnt3++;
    if (ram_wr3 === 1'b1) wr_cnt3++;
    if (ram_rd3 === 1'b1 && ram_wr3 === 1'b1) both3++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts cycles until done is seen on the chosen instance; -1 if it never comes.
  task automatic wait_done(input bit use3, output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if ((use3 ? done3 : done1) === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req1 = 0; op1 = 0; addr1 = 0; wdata1 = 0; wbit1 = 0;
    req3 = 0; op3 = 0; addr3 = 0; wdata3 = 0; wbit3 = 0;
    repeat (3) tick();
    checks++; if (busy1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b exp 0", busy1); end
    checks++; if (done1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_done: got %b exp 0", done1); end
    checks++; if (rdata1 !== 8'h00) begin failures++; $display("[TB] FAIL rst_rdata: got %h exp 00", rdata1); end
    checks++; if (rbit1 !== 1'b0) begin failures++; $display("[TB] FAIL rst_rbit: got %b exp 0", rbit1); end
    checks++; if ({ram_rd1, ram_wr1} !== 2'b00) begin failures++; $display("[TB] FAIL rst_strobes: got %b exp 00", {ram_rd1, ram_wr1}); end
    checks++; if ({ram_addr1, ram_wdata1} !== 16'h0000) begin failures++; $display("[TB] FAIL rst_ram_bus: got %h exp 0000", {ram_addr1, ram_wdata1}); end
    checks++; if ({busy3, done3, ram_rd3, ram_wr3} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_dut3: got %b exp 0000", {busy3, done3, ram_rd3, ram_wr3}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_byte_write();
    int rd0;
    rd0 = rd_cnt1;
    req1 = 1; op1 = 2'b01; addr1 = 8'h30; wdata1 = 8'hA5;
    tick();
    req1 = 0; wdata1 = 8'h00;
    checks++; if (ram_wr1 !== 1'b1) begin failures++; $display("[TB] FAIL bw_wr_k1: got %b exp 1", ram_wr1); end
    checks++; if (ram_addr1 !== 8'h30) begin failures++; $display("[TB] FAIL bw_addr: got %h exp 30", ram_addr1); end
    checks++; if (ram_wdata1 !== 8'hA5) begin failures++; $display("[TB] FAIL bw_wdata: got %h exp A5", ram_wdata1); end
    checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin failures++; $display("[TB] FAIL bw_busy_k1: got busy=%b done=%b exp 1/0", busy1, done1); end
    tick();
    checks++; if (done1 !== 1'b1 || ram_wr1 !== 1'b0) begin failures++; $display("[TB] FAIL bw_done_k2: got done=%b wr=%b exp 1/0", done1, ram_wr1); end
    tick();
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0 || ram_addr1 !== 8'h00) begin failures++; $display("[TB] FAIL bw_idle: got done=%b busy=%b addr=%h exp 0/0/00", done1, busy1, ram_addr1); end
    checks++; if (mem1[8'h30] !== 8'hA5) begin failures++; $display("[TB] FAIL bw_mem: got %h exp A5", mem1[8'h30]); end
    checks++; if (rd_cnt1 !== rd0) begin failures++; $display("[TB] FAIL bw_no_rd: got %0d reads exp 0", rd_cnt1 - rd0); end
  endtask

  task automatic test_byte_read();
    int lat;
    mem1[8'h90] = 8'h3C;
    req1 = 1; op1 = 2'b00; addr1 = 8'h90;
    tick();
    req1 = 0;
    checks++; if (ram_rd1 !== 1'b1 || ram_wr1 !== 1'b0 || ram_addr1 !== 8'h90) begin failures++; $display("[TB] FAIL br_issue: got rd=%b wr=%b addr=%h exp 1/0/90", ram_rd1, ram_wr1, ram_addr1); end
    wait_done(1'b0, lat);
    checks++; if (lat + 1 !== 3) begin failures++; $display("[TB] FAIL br_latency: got %0d exp 3", lat + 1); end
    checks++; if (rdata1 !== 8'h3C) begin failures++; $display("[TB] FAIL br_rdata: got %h exp 3C", rdata1); end
    tick();
  endtask

  task automatic test_bit_write();
    int lat;
    mem1[8'h21] = 8'h00;
    req1 = 1; op1 = 2'b11; addr1 = 8'h0B; wbit1 = 1'b1;
    tick();
    req1 = 0; wbit1 = 1'b0;
    checks++; if (ram_rd1 !== 1'b1 || ram_addr1 !== 8'h21) begin failures++; $display("[TB] FAIL bwr_issue: got rd=%b addr=%h exp 1/21", ram_rd1, ram_addr1); end
    tick();
    checks++; if (ram_wr1 !== 1'b0 || ram_rd1 !== 1'b0 || ram_addr1 !== 8'h21) begin failures++; $display("[TB] FAIL bwr_wait: got rd=%b wr=%b addr=%h exp 0/0/21", ram_rd1, ram_wr1, ram_addr1); end
    tick();
    checks++; if (ram_wr1 !== 1'b1 || ram_addr1 !== 8'h21 || ram_wdata1 !== 8'h08) begin failures++; $display("[TB] FAIL bwr_write: got wr=%b addr=%h data=%h exp 1/21/08", ram_wr1, ram_addr1, ram_wdata1); end
    tick();
    checks++; if (done1 !== 1'b1) begin failures++; $display("[TB] FAIL bwr_done_k4: got %b exp 1", done1); end
    tick();
    checks++; if (mem1[8'h21] !== 8'h08) begin failures++; $display("[TB] FAIL bwr_mem: got %h exp 08", mem1[8'h21]); end
    // SFR bit 0x8D -> byte 0x88 bit 5 cleared, neighbours untouched.
    mem1[8'h88] = 8'hFF;
    req1 = 1; op1 = 2'b11; addr1 = 8'h8D; wbit1 = 1'b0;
    tick();
    req1 = 0;
    checks++; if (ram_addr1 !== 8'h88) begin failures++; $display("[TB] FAIL bwr_sfr_addr: got %h exp 88", ram_addr1); end
    wait_done(1'b0, lat);
    checks++; if (lat + 1 !== 4) begin failures++; $display("[TB] FAIL bwr_sfr_latency: got %0d exp 4", lat + 1); end
    tick();
    checks++; if (mem1[8'h88] !== 8'hDF) begin failures++; $display("[TB] FAIL bwr_sfr_mem: got %h exp DF", mem1[8'h88]); end
  endtask

  task automatic test_bit_read();
    int lat;
    mem1[8'hE0] = 8'h80;
    req1 = 1; op1 = 2'b10; addr1 = 8'hE7;
    tick();
    req1 = 0;
    checks++; if (ram_addr1 !== 8'hE0 || ram_rd1 !== 1'b1) begin failures++; $display("[TB] FAIL brd_issue: got addr=%h rd=%b exp E0/1", ram_addr1, ram_rd1); end
    wait_done(1'b0, lat);
    checks++; if (lat + 1 !== 3) begin failures++; $display("[TB] FAIL brd_latency: got %0d exp 3", lat + 1); end
    checks++; if (rbit1 !== 1'b1) begin failures++; $display("[TB] FAIL brd_rbit: got %b exp 1", rbit1); end
    checks++; if (rdata1 !== 8'h3C) begin failures++; $display("[TB] FAIL brd_rdata_held: got %h exp 3C", rdata1); end
    tick();
    // Bit 0 of the same byte is clear.
    req1 = 1; op1 = 2'b10; addr1 = 8'hE0;
    tick();
    req1 = 0;
    wait_done(1'b0, lat);
    checks++; if (rbit1 !== 1'b0) begin failures++; $display("[TB] FAIL brd_rbit0: got %b exp 0", rbit1); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int wr0;
    mem1[8'h2F] = 8'hFF;
    wr0 = wr_cnt1;
    req1 = 1; op1 = 2'b11; addr1 = 8'h7F; wbit1 = 1'b0;
    tick();
    req1 = 0;
    checks++; if (ram_addr1 !== 8'h2F) begin failures++; $display("[TB] FAIL rmo_addr: got %h exp 2F", ram_addr1); end
    tick();
    reset = 1'b1;
    tick();
    checks++; if ({busy1, done1, ram_rd1, ram_wr1, rbit1} !== 5'b00000) begin failures++; $display("[TB] FAIL rmo_ctrl: got %b exp 00000", {busy1, done1, ram_rd1, ram_wr1, rbit1}); end
    checks++; if ({ram_addr1, ram_wdata1, rdata1} !== 24'h000000) begin failures++; $display("[TB] FAIL rmo_data: got %h exp 000000", {ram_addr1, ram_wdata1, rdata1}); end
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (wr_cnt1 !== wr0) begin failures++; $display("[TB] FAIL rmo_no_wr: got %0d writes exp 0", wr_cnt1 - wr0); end
    checks++; if (mem1[8'h2F] !== 8'hFF) begin failures++; $display("[TB] FAIL rmo_mem: got %h exp FF", mem1[8'h2F]); end
  endtask

  task automatic test_back_to_back();
    int d1[$];
    int d3[$];
    int rd1_0, rd3_0;
    mem3[8'hE0] = 8'h80;
    rd1_0 = rd_cnt1;
    rd3_0 = rd_cnt3;
    req1 = 1; op1 = 2'b00; addr1 = 8'h90;
    req3 = 1; op3 = 2'b10; addr3 = 8'hE7;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (done1 === 1'b1) d1.push_back(c);
      if (done3 === 1'b1) d3.push_back(c);
    end
    req1 = 0;
    req3 = 0;
    repeat (8) tick();
    checks++; if (d1.size() !== 3) begin failures++; $display("[TB] FAIL b2b1_count: got %0d dones exp 3", d1.size()); end
    else begin
      checks++; if (d1[0] !== 3 || d1[1] !== 7 || d1[2] !== 11) begin failures++; $display("[TB] FAIL b2b1_cycles: got %0d,%0d,%0d exp 3,7,11", d1[0], d1[1], d1[2]); end
    end
    checks++; if (rd_cnt1 - rd1_0 !== 3) begin failures++; $display("[TB] FAIL b2b1_reads: got %0d exp 3", rd_cnt1 - rd1_0); end
    checks++; if (d3.size() !== 2) begin failures++; $display("[TB] FAIL b2b3_count: got %0d dones exp 2", d3.size()); end
    else begin
      checks++; if (d3[0] !== 5 || d3[1] !== 11) begin failures++; $display("[TB] FAIL b2b3_cycles: got %0d,%0d exp 5,11", d3[0], d3[1]); end
    end
    checks++; if (rd_cnt3 - rd3_0 !== 2) begin failures++; $display("[TB] FAIL b2b3_reads: got %0d exp 2", rd_cnt3 - rd3_0); end
    checks++; if (rbit3 !== 1'b1 || busy3 !== 1'b0 || busy1 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_end: got rbit3=%b busy3=%b busy1=%b exp 1/0/0", rbit3, busy3, busy1); end
  endtask

  task automatic test_latency3();
    int lat;
    mem3[8'h50] = 8'hC3;
    mem3[8'h21] = 8'h00;
    req3 = 1; op3 = 2'b00; addr3 = 8'h50;
    tick();
    req3 = 0;
    wait_done(1'b1, lat);
    checks++; if (lat + 1 !== 5) begin failures++; $display("[TB] FAIL l3_br_latency: got %0d exp 5", lat + 1); end
    checks++; if (rdata3 !== 8'hC3) begin failures++; $display("[TB] FAIL l3_br_rdata: got %h exp C3", rdata3); end
    tick();
    req3 = 1; op3 = 2'b11; addr3 = 8'h0B; wbit3 = 1'b1;
    tick();
    req3 = 0;
    wait_done(1'b1, lat);
    checks++; if (lat + 1 !== 6) begin failures++; $display("[TB] FAIL l3_bwr_latency: got %0d exp 6", lat + 1); end
    tick();
    checks++; if (mem3[8'h21] !== 8'h08) begin failures++; $display("[TB] FAIL l3_bwr_mem: got %h exp 08", mem3[8'h21]); end
    req3 = 1; op3 = 2'b01; addr3 = 8'h44; wdata3 = 8'h5C;
    tick();
    req3 = 0;
    wait_done(1'b1, lat);
    checks++; if (lat + 1 !== 2) begin failures++; $display("[TB] FAIL l3_bw_latency: got %0d exp 2", lat + 1); end
    tick();
    checks++; if (mem3[8'h44] !== 8'h5C) begin failures++; $display("[TB] FAIL l3_bw_mem: got %h exp 5C", mem3[8'h44]); end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_byte_read();
    test_bit_write();
    test_bit_read();
    test_reset_mid_op();
    test_latency3();
    test_back_to_back();
    checks++; if (both1 !== 0 || both3 !== 0) begin failures++; $display("[TB] FAIL rd_wr_overlap: got %0d/%0d exp 0/0", both1, both3); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
